font_loader_ctrl: RTL and testbench

FONT_LOADER_CTRL -- requirements
Module: font_loader_ctrl

---
 rtl/font_loader_ctrl_if.sv | 37 +++
 rtl/font_loader_ctrl.sv | 163 ++++++++++++++++
 tb/tb_font_loader_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/font_loader_ctrl_if.sv
// Bus bundle between font_loader_ctrl and its string buffer, font ROM and display RAM.
// master = controller side, slave = memory/host side.
interface font_loader_ctrl_if #(
    parameter int COLS_PER_CHAR = 5,
    parameter int MAX_CHARS     = 16,
    parameter int ROM_CHARS     = 128,
    parameter int ASCII_W       = 8,
    parameter int COL_W         = 8
);
    localparam int LEN_W  = $clog2(MAX_CHARS + 1);
    localparam int IDX_W  = $clog2(MAX_CHARS);
    localparam int ROM_AW = $clog2(ROM_CHARS * COLS_PER_CHAR);
    localparam int RAM_AW = $clog2(MAX_CHARS * (COLS_PER_CHAR + 1));

    logic              new_string;
    logic [LEN_W-1:0]  str_len;
    logic [IDX_W-1:0]  str_idx;
    logic [ASCII_W-1:0] ascii_in;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_rd;
    logic [COL_W-1:0]  rom_data;
    logic [RAM_AW-1:0] ram_addr;
    logic [COL_W-1:0]  ram_din;
    logic              ram_we;
    logic              busy;
    logic              done;

    modport master (
        input  new_string, str_len, ascii_in, rom_data,
        output str_idx, rom_addr, rom_rd, ram_addr, ram_din, ram_we, busy, done
    );

    modport slave (
        output new_string, str_len, ascii_in, rom_data,
        input  str_idx, rom_addr, rom_rd, ram_addr, ram_din, ram_we, busy, done
    );
endinterface

// File: rtl/font_loader_ctrl.sv
// Copies font columns for a string of characters from the font ROM into display RAM.
// Define FONT_LOADER_BLANK_COL_EN to append one blank column after every character.
module font_loader_ctrl #(
    parameter int COLS_PER_CHAR = 5,
    parameter int MAX_CHARS     = 16,
    parameter int ROM_CHARS     = 128,
    parameter int ASCII_W       = 8,
    parameter int COL_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    font_loader_ctrl_if.master bus
);
    localparam int LEN_W  = $clog2(MAX_CHARS + 1);
    localparam int IDX_W  = $clog2(MAX_CHARS);
    localparam int ROM_AW = $clog2(ROM_CHARS * COLS_PER_CHAR);
    localparam int RAM_AW = $clog2(MAX_CHARS * (COLS_PER_CHAR + 1));
    localparam int COL_CW = $clog2(COLS_PER_CHAR + 1);
    localparam int MUL_CW = $clog2(ASCII_W + 1);

    localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(MAX_CHARS);
    localparam logic [ASCII_W:0]   ROM_LIMIT  = (ASCII_W + 1)'(ROM_CHARS);
    localparam logic [COL_CW-1:0]  LAST_COL   = COL_CW'(COLS_PER_CHAR - 1);
    localparam logic [MUL_CW-1:0]  LAST_MUL   = MUL_CW'(ASCII_W - 1);
    localparam logic [ROM_AW-1:0]  COLS_MCAND = ROM_AW'(COLS_PER_CHAR);

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, MUL, RD, WR, GAP, NEXT, DONE
    } state_t;

    state_t             state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   char_reg;
    logic [COL_CW-1:0]  col_reg;
    logic [RAM_AW-1:0]  ram_cnt_reg;
    logic [ASCII_W-1:0] code_reg;
    logic [ROM_AW-1:0]  mcand_reg;
    logic [ROM_AW-1:0]  acc_reg;
    logic [MUL_CW-1:0]  mul_cnt_reg;
    logic [ROM_AW-1:0]  rom_addr_reg;
    logic               rom_rd_reg;
    logic               ram_we_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [LEN_W-1:0]   len_next;
    logic [ROM_AW-1:0]  mul_sum;
    logic [LEN_W-1:0]   char_next;

    assign len_next  = (bus.str_len > MAX_LEN) ? MAX_LEN : bus.str_len;
    // One shift-add step: add the shifted multiplicand when the current code LSB is set.
    assign mul_sum   = code_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign char_next = char_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            char_reg     <= '0;
            col_reg      <= '0;
            ram_cnt_reg  <= '0;
            code_reg     <= '0;
            mcand_reg    <= '0;
            acc_reg      <= '0;
            mul_cnt_reg  <= '0;
            rom_addr_reg <= '0;
            rom_rd_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            rom_rd_reg <= 1'b0;
            ram_we_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.new_string) begin
                        len_reg     <= len_next;
                        char_reg    <= '0;
                        col_reg     <= '0;
                        ram_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        if (len_next == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                FETCH: state_reg <= LOAD;
                LOAD: begin
                    // Codes outside the ROM fall back to glyph 0.
                    code_reg    <= ({1'b0, bus.ascii_in} >= ROM_LIMIT) ? '0 : bus.ascii_in;
                    mcand_reg   <= COLS_MCAND;
                    acc_reg     <= '0;
                    mul_cnt_reg <= '0;
                    state_reg   <= MUL;
                end
                MUL: begin
                    acc_reg     <= mul_sum;
                    code_reg    <= code_reg >> 1;
                    mcand_reg   <= mcand_reg << 1;
                    mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    if (mul_cnt_reg == LAST_MUL) begin
                        rom_addr_reg <= mul_sum;
                        rom_rd_reg   <= 1'b1;
                        state_reg    <= RD;
                    end
                end
                RD: begin
                    ram_we_reg <= 1'b1;
                    state_reg  <= WR;
                end
                WR: begin
                    ram_cnt_reg <= ram_cnt_reg + 1'b1;
                    if (col_reg < LAST_COL) begin
                        col_reg      <= col_reg + 1'b1;
                        rom_addr_reg <= rom_addr_reg + 1'b1;
                        rom_rd_reg   <= 1'b1;
                        state_reg    <= RD;
                    end else begin
`ifdef FONT_LOADER_BLANK_COL_EN
                        ram_we_reg <= 1'b1;
                        state_reg  <= GAP;
`else
                        state_reg  <= NEXT;
`endif
                    end
                end
                GAP: begin
                    ram_cnt_reg <= ram_cnt_reg + 1'b1;
                    state_reg   <= NEXT;
                end
                NEXT: begin
                    char_reg <= char_next;
                    col_reg  <= '0;
                    if (char_next == len_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.str_idx  = char_reg[IDX_W-1:0];
    assign bus.rom_addr = rom_addr_reg;
    assign bus.rom_rd   = rom_rd_reg;
    assign bus.ram_addr = ram_cnt_reg;
    // ROM data only arrives during WR, so the write data is steered rather than registered.
    assign bus.ram_din  = (state_reg == WR) ? bus.rom_data : '0;
    assign bus.ram_we   = ram_we_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_font_loader_ctrl.sv
// Scoreboard bench for font_loader_ctrl: stimulus pushes expected ROM reads, RAM writes
// and done cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_font_loader_ctrl;
`ifdef FONT_LOADER_BLANK_COL_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    localparam int COLS   = 5;
    localparam int STRIDE = COLS + GAP;
    localparam int PER    = 2 + 8 + 2 * COLS + GAP + 1;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    font_loader_ctrl_if bus ();
    font_loader_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] sbuf [16];
    wr_t        wr_q  [$];
    logic [9:0] rom_q [$];
    int         done_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // String buffer with registered read; ROM returns its own address one cycle after rom_rd.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ascii_in <= '0;
            bus.rom_data <= '0;
        end else begin
            bus.ascii_in <= sbuf[bus.str_idx];
            if (bus.rom_rd) bus.rom_data <= bus.rom_addr[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected event (value %0h) expected none", name, act);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_rd) begin
                if (rom_q.size() == 0) flag("rom_rd_extra", bus.rom_addr);
                else check("rom_addr", bus.rom_addr, rom_q.pop_front());
            end
            if (bus.ram_we) begin
                if (wr_q.size() == 0) flag("ram_we_extra", bus.ram_addr);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    $display("[TB] write addr=%0d data=%02h", bus.ram_addr, bus.ram_din);
                    check("ram_addr", bus.ram_addr, w.a);
                    check("ram_din", bus.ram_din, w.d);
                    check("busy_on_write", bus.busy, 1);
                end
            end else begin
                check("ram_din_idle", bus.ram_din, 0);
            end
            if (bus.done) begin
                if (done_q.size() == 0) flag("done_extra", cyc);
                else begin
                    $display("[TB] done at cycle %0d", cyc);
                    check("done_cycle", cyc, done_q.pop_front());
                    check("busy_at_done", bus.busy, 1);
                end
            end
        end
    end

    task automatic push_model(input int len, input int start);
        int lenq;
        int ram;
        lenq = (len > 16) ? 16 : len;
        ram = 0;
        for (int c = 0; c < lenq; c++) begin
            int code;
            int base;
            code = sbuf[c];
            if (code >= 128) code = 0;
            base = code * COLS;
            for (int col = 0; col < COLS; col++) begin
                wr_t w;
                int v;
                v = base + col;
                w.a = ram[6:0];
                w.d = v[7:0];
                rom_q.push_back(v[9:0]);
                wr_q.push_back(w);
                ram++;
            end
            if (GAP == 1) begin
                wr_t g;
                g.a = ram[6:0];
                g.d = 8'h00;
                wr_q.push_back(g);
                ram++;
            end
        end
        done_q.push_back(start + 1 + lenq * PER);
    endtask

    task automatic pulse_new(input int len);
        @(posedge clk); #1;
        bus.new_string = 1'b1;
        bus.str_len    = len[4:0];
        @(posedge clk); #1;
        bus.new_string = 1'b0;
    endtask

    task automatic start_load(input int len);
        @(posedge clk); #1;
        push_model(len, cyc);
        bus.new_string = 1'b1;
        bus.str_len    = len[4:0];
        @(posedge clk); #1;
        bus.new_string = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((wr_q.size() != 0 || rom_q.size() != 0 || done_q.size() != 0 || bus.busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: got %0d cycles required < 3000", name, n);
        end
        check({name, "_busy_low"}, bus.busy, 0);
        check({name, "_queues_empty"}, wr_q.size() + rom_q.size() + done_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_rom_rd"}, bus.rom_rd, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_str_idx"}, bus.str_idx, 0);
        check({tag, "_ram_din"}, bus.ram_din, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int st;
        rst_n = 1'b0;
        bus.new_string = 1'b0;
        bus.str_len = '0;
        for (int i = 0; i < 16; i++) sbuf[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Single 'A', expectations written out by hand
        sbuf[0] = 8'h41;
        @(posedge clk); #1;
        st = cyc;
        for (int col = 0; col < 5; col++) begin
            wr_t w;
            int v;
            v = 325 + col;
            rom_q.push_back(v[9:0]);
            w.a = col[6:0];
            w.d = 8'h45 + col[7:0];
            wr_q.push_back(w);
        end
        if (GAP == 1) wr_q.push_back(wr_t'({7'd5, 8'h00}));
        done_q.push_back(st + 22 + GAP);
        bus.new_string = 1'b1;
        bus.str_len = 5'd1;
        @(posedge clk); #1;
        bus.new_string = 1'b0;
        wait_idle("single_A");

        // "ABC" with an extra start request while busy
        sbuf[0] = 8'h41; sbuf[1] = 8'h42; sbuf[2] = 8'h43;
        start_load(3);
        pulse_new(5);
        wait_idle("abc");

        // Empty string
        start_load(0);
        wait_idle("empty");

        // Oversized length clamps to 16 characters, some codes out of ROM range
        for (int i = 0; i < 16; i++) sbuf[i] = 8'h20 + 8'(i * 7);
        start_load(20);
        wait_idle("clamp20");

        // Out-of-range code maps to glyph 0
        sbuf[0] = 8'hC8;
        start_load(1);
        wait_idle("code_c8");

        // Reset during the second character, then restart
        sbuf[0] = 8'h41; sbuf[1] = 8'h42; sbuf[2] = 8'h43;
        start_load(3);
        pulse_new(1);
        n = 0;
        while (!(bus.ram_we && bus.ram_addr == 7'(STRIDE)) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL midreset_wait: got %0d cycles required < 500", n);
        end
        rst_n = 1'b0;
        wr_q.delete();
        rom_q.delete();
        done_q.delete();
        @(negedge clk);
        check_zero("midreset");
        repeat (2) @(negedge clk);
        check("midreset_done_hold", bus.done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("after_midreset");
        sbuf[0] = 8'h41;
        start_load(1);
        wait_idle("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
